exe_hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline, successor to the combinational EX forwarding unit. It keeps its own shadow copy of the destination fields of the EX, MEM and WB stages, so the datapath only supplies decode-stage fields. From that copy it produces:
- per-operand EX forwarding selects for any number of read ports,
- load-use stalls,
- multi-cycle multiply/divide (MDU) busy interlocks,
- a stall-cycle performance counter.

---
 rtl/exe_hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_exe_hazard_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline. It keeps a shadow copy of the
// EX/MEM/WB destinations, and from it drives the EX forwarding selects, the stalls and the MDU interlock.
module exe_hazard_scoreboard #(
  parameter int unsigned NRP     = 2,
  parameter int unsigned WSW     = 3,
  parameter int unsigned NWS     = 4,
  parameter int unsigned FWW     = 3,
  parameter int unsigned LOAD_WS = 1,
  parameter int unsigned MDU_LAT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [NRP*5-1:0]   id_ra,
  input  logic [NRP-1:0]     id_ra_used,
  input  logic               id_we,
  input  logic [4:0]         id_wa,
  input  logic [WSW-1:0]     id_ws,
  input  logic               id_mdu_start,
  input  logic               id_mdu_read,
  input  logic               flush,
  output logic               stall,
  output logic [NRP*FWW-1:0] ex_fw_src,
  output logic               mdu_busy,
  output logic [31:0]        stall_cycles
);

  localparam logic [FWW-1:0] WbSel  = FWW'(NWS + 1);
  localparam logic [FWW-1:0] OneSel = FWW'(1);
  localparam logic [WSW-1:0] LoadWs = WSW'(LOAD_WS);
  localparam logic [7:0]     MduLat = 8'(MDU_LAT);

  logic               ex_we_q, mem_we_q, wb_we_q;
  logic [4:0]         ex_wa_q, mem_wa_q, wb_wa_q;
  logic [WSW-1:0]     ex_ws_q, mem_ws_q, wb_ws_q;
  logic [NRP*5-1:0]   ex_ra_q;
  logic [NRP-1:0]     ex_used_q;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        stall_cycles_q;

  logic lu, mu, ex_load, mdu_accept;

  always_comb begin
    lu = 1'b0;
    for (int k = 0; k < NRP; k++) begin
      if (id_ra_used[k] && (id_ra[5*k +: 5] != 5'd0) && ex_we_q && (ex_ws_q == LoadWs) &&
          (ex_wa_q == id_ra[5*k +: 5])) begin
        lu = 1'b1;
      end
    end
    lu = lu & id_valid;
  end

  assign mdu_busy   = (cnt_q != 8'd0);
  assign mu         = id_valid & (id_mdu_start | id_mdu_read) & mdu_busy;
  // A squashed instruction must never hold the front end.
  assign stall      = (lu | mu) & ~flush;
  assign ex_load    = id_valid & ~stall & ~flush;
  assign mdu_accept = id_valid & id_mdu_start & ~stall & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    if (mdu_accept) begin
      cnt_d = MduLat;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // MEM has priority over WB; r0 is never forwarded.
  always_comb begin
    ex_fw_src = '0;
    for (int k = 0; k < NRP; k++) begin
      if (ex_used_q[k] && (ex_ra_q[5*k +: 5] != 5'd0)) begin
        if (mem_we_q && (mem_wa_q == ex_ra_q[5*k +: 5])) begin
          ex_fw_src[FWW*k +: FWW] = FWW'(mem_ws_q) + OneSel;
        end else if (wb_we_q && (wb_wa_q == ex_ra_q[5*k +: 5])) begin
          ex_fw_src[FWW*k +: FWW] = WbSel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_we_q        <= 1'b0;
      ex_wa_q        <= 5'd0;
      ex_ws_q        <= '0;
      ex_ra_q        <= '0;
      ex_used_q      <= '0;
      mem_we_q       <= 1'b0;
      mem_wa_q       <= 5'd0;
      mem_ws_q       <= '0;
      wb_we_q        <= 1'b0;
      wb_wa_q        <= 5'd0;
      wb_ws_q        <= '0;
      cnt_q          <= 8'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      mem_we_q <= ex_we_q;
      mem_wa_q <= ex_wa_q;
      mem_ws_q <= ex_ws_q;
      wb_we_q  <= mem_we_q;
      wb_wa_q  <= mem_wa_q;
      wb_ws_q  <= mem_ws_q;
      if (ex_load) begin
        ex_we_q   <= id_we;
        ex_wa_q   <= id_wa;
        ex_ws_q   <= id_ws;
        ex_ra_q   <= id_ra;
        ex_used_q <= id_ra_used;
      end else begin
        ex_we_q   <= 1'b0;
        ex_used_q <= '0;
      end
      cnt_q <= cnt_d;
      if (stall) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_exe_hazard_scoreboard.sv
// Self-checking bench for exe_hazard_scoreboard (NRP=3, MDU_LAT=4): directed scenarios plus
// randomized traffic against an issue-history reference model.
module tb_exe_hazard_scoreboard;
  localparam int NRP = 3;
  localparam int WSW = 3;
  localparam int NWS = 4;
  localparam int FWW = 3;
  localparam int LOAD_WS = 1;
  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [NRP*5-1:0] id_ra;
  logic [NRP-1:0]   id_ra_used;
  logic             id_we;
  logic [4:0]       id_wa;
  logic [WSW-1:0]   id_ws;
  logic             id_mdu_start;
  logic             id_mdu_read;
  logic             flush;
  logic             stall;
  logic [NRP*FWW-1:0] ex_fw_src;
  logic             mdu_busy;
  logic [31:0]      stall_cycles;

  exe_hazard_scoreboard #(
    .NRP(NRP), .WSW(WSW), .NWS(NWS), .FWW(FWW), .LOAD_WS(LOAD_WS), .MDU_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_ra_used(id_ra_used),
    .id_we(id_we), .id_wa(id_wa), .id_ws(id_ws), .id_mdu_start(id_mdu_start),
    .id_mdu_read(id_mdu_read), .flush(flush), .stall(stall), .ex_fw_src(ex_fw_src),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the last three issued instructions (index 0 = newest, now in EX),
  // an absolute cycle number, and the last cycle at which the MDU is still busy.
  typedef struct packed {
    logic             we;
    logic [4:0]       wa;
    logic [WSW-1:0]   ws;
    logic [NRP*5-1:0] ra;
    logic [NRP-1:0]   used;
  } instr_t;

  instr_t      hist[3];
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] m_stalls = 0;

  function automatic logic [NRP*FWW-1:0] m_fw();
    logic [NRP*FWW-1:0] v;
    logic [4:0] r;
    v = '0;
    for (int k = 0; k < NRP; k++) begin
      r = hist[0].ra[5*k +: 5];
      if (hist[0].used[k] && r != 0) begin
        if (hist[1].we && hist[1].wa == r) v[FWW*k +: FWW] = FWW'(int'(hist[1].ws) + 1);
        else if (hist[2].we && hist[2].wa == r) v[FWW*k +: FWW] = FWW'(NWS + 1);
      end
    end
    return v;
  endfunction

  function automatic logic m_busy();
    return cyc <= busy_until;
  endfunction

  function automatic logic m_stall();
    logic lu;
    lu = 1'b0;
    for (int k = 0; k < NRP; k++)
      if (id_valid && id_ra_used[k] && id_ra[5*k +: 5] != 0 && hist[0].we &&
          int'(hist[0].ws) == LOAD_WS && hist[0].wa == id_ra[5*k +: 5]) lu = 1'b1;
    return (lu || (id_valid && (id_mdu_start || id_mdu_read) && m_busy())) && !flush;
  endfunction

  task automatic tick();
    logic s;
    instr_t n;
    s = m_stall();
    n = '0;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      busy_until = -1;
      m_stalls = 0;
    end else begin
      if (s) m_stalls = m_stalls + 1;
      if (id_valid && id_mdu_start && !s && !flush) busy_until = cyc + LAT;
      if (id_valid && !s && !flush) n = '{id_we, id_wa, id_ws, id_ra, id_ra_used};
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; id_valid = 1'b0; id_ra = '0; id_ra_used = '0; id_we = 1'b0; id_wa = 5'd0;
    id_ws = '0; id_mdu_start = 1'b0; id_mdu_read = 1'b0; flush = 1'b0;
  endtask

  task automatic set_instr(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [2:0] used, input logic we, input logic [4:0] wa,
                           input logic [2:0] ws);
    id_valid = 1'b1; id_ra = {r2, r1, r0}; id_ra_used = used; id_we = we; id_wa = wa; id_ws = ws;
    id_mdu_start = 1'b0; id_mdu_read = 1'b0; flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NRP; k++) id_ra[5*k +: 5] = 5'($urandom_range(0, 7));
    id_ra_used = 3'($urandom);
    id_we = 1'($urandom);
    id_wa = 5'($urandom_range(0, 7));
    id_ws = 3'($urandom_range(0, NWS - 1));
    id_mdu_start = ($urandom_range(0, 9) == 0);
    id_mdu_read = ($urandom_range(0, 5) == 0);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    randomize_inputs();
    flush = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
    checks++; if (ex_fw_src !== '0) begin failures++; $display("FAIL reset_fw: got %h want 0", ex_fw_src); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
    tick();
    set_idle();
    repeat (6) tick();
  endtask

  task automatic test_alu_chain();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd3, 3'd0);
    tick();
    set_instr(5'd3, 5'd0, 5'd0, 3'b001, 1'b1, 5'd6, 3'd0);
    tick();
    set_instr(5'd3, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 3'd0);
    #1;
    checks++; if (ex_fw_src !== 9'o001) begin failures++; $display("FAIL alu_mem_fw: got %o want 001", ex_fw_src); end
    tick();
    set_idle();
    #1;
    checks++; if (ex_fw_src[2:0] !== 3'd5) begin failures++; $display("FAIL alu_wb_fw: got %0d want 5", ex_fw_src[2:0]); end
    repeat (3) tick();
  endtask

  task automatic test_double_match();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd4, 3'd2);
    tick();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd4, 3'd3);
    tick();
    set_instr(5'd4, 5'd4, 5'd0, 3'b011, 1'b0, 5'd0, 3'd0);
    tick();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd0, 3'd0);
    #1;
    checks++; if (ex_fw_src !== 9'o044) begin failures++; $display("FAIL double_fw: got %o want 044", ex_fw_src); end
    tick();
    set_instr(5'd0, 5'd0, 5'd0, 3'b111, 1'b0, 5'd0, 3'd0);
    tick();
    set_idle();
    #1;
    checks++; if (ex_fw_src !== '0) begin failures++; $display("FAIL r0_fw: got %o want 0", ex_fw_src); end
    repeat (3) tick();
  endtask

  task automatic test_port2();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd9, 3'd3);
    tick();
    set_instr(5'd1, 5'd2, 5'd9, 3'b111, 1'b0, 5'd0, 3'd0);
    tick();
    set_idle();
    #1;
    checks++; if (ex_fw_src !== 9'o400) begin failures++; $display("FAIL port2_fw: got %o want 400", ex_fw_src); end
    repeat (3) tick();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = m_stalls;
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd5, 3'd1);
    tick();
    set_instr(5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 5'd7, 3'd0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %b want 1", stall); end
    tick();
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_release: got %b want 0", stall); end
    checks++; if (stall_cycles !== base + 1) begin failures++; $display("FAIL lu_count: got %0d want %0d", stall_cycles, base + 1); end
    tick();
    set_idle();
    #1;
    // After the bubble the load has moved on to WB by the time the consumer is in EX.
    checks++; if (ex_fw_src[2:0] !== 3'(NWS + 1)) begin failures++; $display("FAIL lu_fw: got %0d want %0d", ex_fw_src[2:0], NWS + 1); end
    repeat (3) tick();
  endtask

  task automatic test_load_use_flush();
    logic [31:0] base;
    base = m_stalls;
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd5, 3'd1);
    tick();
    set_instr(5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 5'd7, 3'd0);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL luf_stall: got %b want 0", stall); end
    tick();
    set_idle();
    #1;
    checks++; if (ex_fw_src !== '0) begin failures++; $display("FAIL luf_fw: got %o want 0", ex_fw_src); end
    checks++; if (stall_cycles !== base) begin failures++; $display("FAIL luf_count: got %0d want %0d", stall_cycles, base); end
    repeat (3) tick();
  endtask

  task automatic test_mdu();
    logic [31:0] base;
    base = m_stalls;
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 3'd0);
    id_mdu_start = 1'b1;
    #1;
    checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_idle: got %b want 0", mdu_busy); end
    tick();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd8, 3'd2);
    id_mdu_read = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      #1;
      checks++; if (mdu_busy !== 1'b1 || stall !== 1'b1) begin
        failures++; $display("FAIL mdu_wait%0d: busy=%b stall=%b want 1 1", i, mdu_busy, stall);
      end
      tick();
    end
    #1;
    checks++; if (mdu_busy !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL mdu_done: busy=%b stall=%b want 0 0", mdu_busy, stall);
    end
    checks++; if (stall_cycles !== base + LAT) begin failures++; $display("FAIL mdu_count: got %0d want %0d", stall_cycles, base + LAT); end
    tick();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 3'd0);
    id_mdu_start = 1'b1;
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mdu_second: got %b want 1", stall); end
    set_idle();
    repeat (LAT + 1) tick();
    checks++; if (mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_drain: got %b want 0", mdu_busy); end
  endtask

  task automatic test_reset_mid_mdu();
    set_instr(5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd3, 3'd0);
    id_mdu_start = 1'b1;
    tick();
    set_instr(5'd3, 5'd0, 5'd0, 3'b001, 1'b1, 5'd3, 3'd1);
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    set_instr(5'd3, 5'd3, 5'd3, 3'b111, 1'b0, 5'd0, 3'd0);
    id_mdu_read = 1'b1;
    #1;
    checks++; if (mdu_busy !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rstmdu_busy: busy=%b stall=%b want 0 0", mdu_busy, stall);
    end
    checks++; if (ex_fw_src !== '0) begin failures++; $display("FAIL rstmdu_fw: got %o want 0", ex_fw_src); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rstmdu_cnt: got %0d want 0", stall_cycles); end
    tick();
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 59) == 0);
      #1;
      checks++; if (stall !== m_stall()) begin failures++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall, m_stall()); end
      checks++; if (ex_fw_src !== m_fw()) begin failures++; $display("FAIL rnd_fw@%0d: got %o want %o", n, ex_fw_src, m_fw()); end
      checks++; if (mdu_busy !== m_busy()) begin failures++; $display("FAIL rnd_busy@%0d: got %b want %b", n, mdu_busy, m_busy()); end
      checks++; if (stall_cycles !== m_stalls) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, stall_cycles, m_stalls); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    @(negedge clk);
    test_reset();
    test_alu_chain();
    test_double_match();
    test_port2();
    test_load_use();
    test_load_use_flush();
    test_mdu();
    test_reset_mid_mdu();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
